// File: rtl/gtp_link_pkg.sv
// ----------------------------------------------------------------------------
// gtp_link_pkg
//  Shared definitions for the GTP link framing layer:
//   - K-code byte constants (K28.5, K27.7, K29.7, K23.7) and the D16.2 idle filler
//   - word-class enum produced by the receive classifier
//   - receive deframer FSM state type
//   - 19-bit receive FIFO word {last, err, odd, data[15:0]}
//   - classify(): maps a received word and its K flags to a word class
// ----------------------------------------------------------------------------
package gtp_link_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] D16_2 = 8'h50;

    localparam logic [15:0] IDLE_WORD = {D16_2, K28_5};
    localparam logic [15:0] SOF_WORD  = {K27_7, K27_7};
    localparam logic [15:0] EOF_WORD  = {K29_7, K29_7};

    typedef enum logic [2:0] {
        W_IDLE,
        W_SOF,
        W_EOF,
        W_DATA,
        W_ODD,
        W_ILLEGAL
    } word_class_e;

    typedef enum logic [2:0] {
        ST_UNSYNC,
        ST_IDLE,
        ST_DATA,
        ST_WAIT_EOF,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic        last;
        logic        err;
        logic        odd;
        logic [15:0] data;
    } wr_word_t;

    // Byte [7:0] is first on the wire; charisk[0] qualifies it.
    function automatic word_class_e classify(input logic [15:0] data, input logic [1:0] charisk);
        word_class_e cls;
        cls = W_ILLEGAL;
        unique case (charisk)
            2'b00: cls = W_DATA;
            2'b01: if (data == IDLE_WORD) cls = W_IDLE;
            2'b10: if (data[15:8] == K23_7) cls = W_ODD;
            2'b11: begin
                if (data == SOF_WORD)      cls = W_SOF;
                else if (data == EOF_WORD) cls = W_EOF;
            end
            default: cls = W_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/gtp_rx_sync_mon.sv
// ----------------------------------------------------------------------------
// gtp_rx_sync_mon
//  Link synchronisation monitor. Counts consecutive IDLE words while link_up is
//  high; the edge that samples the SYNC_IDLE_CNT-th idle sets sync_ok_o. Once
//  synchronised the link stays in sync until link_up drops, which clears sync_ok_o
//  on the sampling edge and restarts the idle count.
// Ports:
//  clk_i       in   RX user clock
//  rst_i       in   asynchronous active-high reset
//  link_up_i   in   GTP reset-done / PLL-lock qualifier
//  is_idle_i   in   current word classifies as IDLE
//  sync_ok_o   out  registered link-synchronised flag
// ----------------------------------------------------------------------------
module gtp_rx_sync_mon #(
    parameter int SYNC_IDLE_CNT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic link_up_i,
    input  logic is_idle_i,
    output logic sync_ok_o
);

    localparam int CW = $clog2(SYNC_IDLE_CNT + 1);

    logic [CW-1:0] cnt_q;
    logic          sync_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else if (!link_up_i) begin
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else if (!sync_q) begin
            if (is_idle_i) begin
                if (cnt_q == CW'(SYNC_IDLE_CNT - 1)) begin
                    cnt_q  <= '0;
                    sync_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                // Any non-idle word breaks the run of consecutive idles.
                cnt_q <= '0;
            end
        end
    end

    assign sync_ok_o = sync_q;

endmodule

// File: rtl/gtp_rx_deframer.sv
// ----------------------------------------------------------------------------
// gtp_rx_deframer
//  Receive-side deframer for the GTP link. Classifies each 16-bit word, tracks
//  link sync (gtp_rx_sync_mon), strips SOF/EOF/idle framing and writes payload
//  words into the receive FIFO with last/err/odd tags. A one-word hold register
//  delays each payload word until the next one (or EOF) shows whether it is the
//  last word of the frame.
//
//  Optional feature: define GTP_RX_CHECKSUM_EN to treat the final payload word
//  of each frame as a modulo-2^16 checksum of the preceding payload words. The
//  checksum is never written; a mismatch tags the last written word with err=1.
//  In that build the hold stage is two words deep (h1 older, h0 newest) and an
//  odd frame carries its checksum word after the ODD_LAST word.
//
// Ports:
//  gt_rxusrclk_in  in   RX user clock
//  reset_in        in   asynchronous active-high reset
//  gt_rxdata       in   received word, byte [7:0] first on wire
//  gt_rxcharisk    in   per-byte K flags
//  link_up         in   low forces loss of sync and aborts an open frame
//  RxFifoProgFull  in   FIFO prog_full, sampled only at SOF
//  RxFifoWrEnb     out  FIFO write strobe
//  RxFifoWrData    out  {last, err, odd, data[15:0]}
//  sync_ok         out  link synchronised
//  frame_cnt       out  good frames written (saturating)
//  drop_cnt        out  frames dropped at SOF due to prog_full (saturating)
//  err_cnt         out  frames ended with err=1 (saturating)
// ----------------------------------------------------------------------------
module gtp_rx_deframer
    import gtp_link_pkg::*;
#(
    parameter int SYNC_IDLE_CNT   = 16,
    parameter int MAX_FRAME_WORDS = 1024,
    parameter int CNT_W           = 16
) (
    input  logic             gt_rxusrclk_in,
    input  logic             reset_in,
    input  logic [15:0]      gt_rxdata,
    input  logic [1:0]       gt_rxcharisk,
    input  logic             link_up,
    input  logic             RxFifoProgFull,
    output logic             RxFifoWrEnb,
    output logic [18:0]      RxFifoWrData,
    output logic             sync_ok,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt
);

`ifdef GTP_RX_CHECKSUM_EN
    localparam int LIMIT = MAX_FRAME_WORDS + 1;  // checksum word rides on top
`else
    localparam int LIMIT = MAX_FRAME_WORDS;
`endif
    localparam int WC_W = $clog2(LIMIT + 1);

    word_class_e     cls;
    logic            sync_ok_w;
    rx_state_e       state_q;
    rx_state_e       sof_state;
    logic            sof_start;

    logic            h0_vld_q;
    logic            h0_odd_q;
    logic [15:0]     h0_data_q;
    logic [WC_W-1:0] wcnt_q;
    logic            at_limit;

    // Word that is written on a mid-frame push, at EOF and on abort.
    logic            pend_vld;
    logic            pend_odd;
    logic [15:0]     pend_data;
    logic            end_write;
    logic            end_err;
    logic            push_to_wait;
    logic            push_bad;

    wr_word_t        abort_word;
    wr_word_t        mid_word;
    wr_word_t        end_word;

    logic            wr_en_q;
    wr_word_t        wr_word_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    assign cls      = classify(gt_rxdata, gt_rxcharisk);
    assign at_limit = (wcnt_q == WC_W'(LIMIT));

    gtp_rx_sync_mon #(
        .SYNC_IDLE_CNT (SYNC_IDLE_CNT)
    ) u_sync_mon (
        .clk_i     (gt_rxusrclk_in),
        .rst_i     (reset_in),
        .link_up_i (link_up),
        .is_idle_i (cls == W_IDLE),
        .sync_ok_o (sync_ok_w)
    );

`ifdef GTP_RX_CHECKSUM_EN
    logic            h1_vld_q;
    logic            h1_odd_q;
    logic [15:0]     h1_data_q;
    logic [15:0]     sum_q;       // sum of every accepted word except h0
    logic            odd_seen_q;
    logic [15:0]     h0_sum_val;

    assign h0_sum_val   = h0_odd_q ? {8'h00, h0_data_q[7:0]} : h0_data_q;
    assign pend_vld     = h1_vld_q;
    assign pend_odd     = h1_odd_q;
    assign pend_data    = h1_data_q;
    // h0 is the checksum at EOF; a frame holding only the checksum writes nothing.
    assign end_write    = h1_vld_q;
    assign end_err      = h0_odd_q || (h0_data_q != sum_q);
    assign push_to_wait = (cls == W_DATA) && odd_seen_q;
    assign push_bad     = (cls == W_ODD) && odd_seen_q;
`else
    assign pend_vld     = h0_vld_q;
    assign pend_odd     = h0_odd_q;
    assign pend_data    = h0_data_q;
    assign end_write    = h0_vld_q;
    assign end_err      = 1'b0;
    assign push_to_wait = (cls == W_ODD);
    assign push_bad     = 1'b0;
`endif

    // A SOF is honoured in IDLE and, after aborting the open frame, in DATA.
    assign sof_start = link_up && (cls == W_SOF) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DATA));
    assign sof_state = RxFifoProgFull ? ST_DROP : ST_DATA;

    // NOTE: every always_comb output gets a full default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        abort_word      = '0;
        abort_word.last = 1'b1;
        abort_word.err  = 1'b1;
        abort_word.odd  = pend_vld & pend_odd;
        abort_word.data = pend_vld ? pend_data : 16'h0000;

        mid_word        = '0;
        mid_word.data   = pend_data;

        end_word        = '0;
        end_word.last   = 1'b1;
        end_word.err    = end_err;
        end_word.odd    = pend_odd;
        end_word.data   = pend_data;
    end

    always_ff @(posedge gt_rxusrclk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_UNSYNC;
            h0_vld_q   <= 1'b0;
            h0_odd_q   <= 1'b0;
            h0_data_q  <= '0;
            wcnt_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_word_q  <= '0;
            drop_cnt_q <= '0;
`ifdef GTP_RX_CHECKSUM_EN
            h1_vld_q   <= 1'b0;
            h1_odd_q   <= 1'b0;
            h1_data_q  <= '0;
            sum_q      <= '0;
            odd_seen_q <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (!link_up) begin
                // Loss of link closes an open frame as an error; a frame being
                // dropped is discarded silently.
                if ((state_q == ST_DATA) || (state_q == ST_WAIT_EOF)) begin
                    wr_en_q   <= 1'b1;
                    wr_word_q <= abort_word;
                end
                state_q <= ST_UNSYNC;
            end else begin
                case (state_q)
                    // The word on the cycle sync is first seen is not parsed.
                    ST_UNSYNC: if (sync_ok_w) state_q <= ST_IDLE;

                    ST_IDLE: ;  // only SOF matters here, handled below

                    ST_DATA: begin
                        case (cls)
                            W_DATA, W_ODD: begin
                                if (at_limit || push_bad) begin
                                    wr_en_q   <= 1'b1;
                                    wr_word_q <= abort_word;
                                    // Truncated frames discard their tail until EOF.
                                    state_q   <= at_limit ? ST_DROP : ST_IDLE;
                                end else begin
                                    if (pend_vld) begin
                                        wr_en_q   <= 1'b1;
                                        wr_word_q <= mid_word;
                                    end
                                    h0_vld_q  <= 1'b1;
                                    h0_odd_q  <= (cls == W_ODD);
                                    h0_data_q <= gt_rxdata;
                                    wcnt_q    <= wcnt_q + 1'b1;
`ifdef GTP_RX_CHECKSUM_EN
                                    h1_vld_q  <= h0_vld_q;
                                    h1_odd_q  <= h0_odd_q;
                                    h1_data_q <= h0_data_q;
                                    sum_q     <= sum_q + (h0_vld_q ? h0_sum_val : 16'h0000);
                                    if (cls == W_ODD) odd_seen_q <= 1'b1;
`endif
                                    if (push_to_wait) state_q <= ST_WAIT_EOF;
                                end
                            end
                            W_EOF: begin
                                if (end_write) begin
                                    wr_en_q   <= 1'b1;
                                    wr_word_q <= end_word;
                                end
                                state_q <= ST_IDLE;
                            end
                            W_SOF: begin
                                // Abort here; the new frame is opened below.
                                wr_en_q   <= 1'b1;
                                wr_word_q <= abort_word;
                            end
                            W_ILLEGAL: begin
                                wr_en_q   <= 1'b1;
                                wr_word_q <= abort_word;
                                state_q   <= ST_IDLE;
                            end
                            default: ;  // idle words inside a frame are skipped
                        endcase
                    end

                    ST_WAIT_EOF: begin
                        if (cls == W_EOF) begin
                            if (end_write) begin
                                wr_en_q   <= 1'b1;
                                wr_word_q <= end_word;
                            end
                            state_q <= ST_IDLE;
                        end else if (cls != W_IDLE) begin
                            wr_en_q   <= 1'b1;
                            wr_word_q <= abort_word;
                            state_q   <= ST_IDLE;
                        end
                    end

                    ST_DROP: begin
                        if ((cls == W_EOF) || (cls == W_ILLEGAL)) state_q <= ST_IDLE;
                    end

                    default: state_q <= ST_UNSYNC;
                endcase

                if (sof_start) begin
                    state_q  <= sof_state;
                    h0_vld_q <= 1'b0;
                    wcnt_q   <= '0;
`ifdef GTP_RX_CHECKSUM_EN
                    h1_vld_q   <= 1'b0;
                    sum_q      <= '0;
                    odd_seen_q <= 1'b0;
`endif
                    if (RxFifoProgFull && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

    // Frame statistics follow the registered FIFO writes, one cycle behind them.
    always_ff @(posedge gt_rxusrclk_in or posedge reset_in) begin
        if (reset_in) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (wr_en_q && wr_word_q.last) begin
            if (wr_word_q.err) begin
                if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            end else begin
                if (!(&frame_cnt_q)) frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign RxFifoWrEnb  = wr_en_q;
    assign RxFifoWrData = wr_word_q;
    assign sync_ok      = sync_ok_w;
    assign frame_cnt    = frame_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule
